// File: rtl/order_flash_gen_if.sv
// Order Tank / order decoder bundle for the Order Flashing Unit.
// The master side drives digit timing and the order train; the slave side returns the decoded fields.
`timescale 1ns/1ps
interface order_flash_gen_if #(
    parameter int OPC_W  = 5,
    parameter int ADDR_W = 10
) ();
    logic              digit_tick;
    logic              mc_start;
    logic              g13;
    logic              epsep;
    logic              order;
    logic [OPC_W-1:0]  opcode;
    logic [OPC_W-1:0]  opcode_n;
    logic [ADDR_W-1:0] addr;
    logic              long_order;
    logic              order_flash_rdy;
    logic              capture_err;

    modport master (
        output digit_tick, mc_start, g13, epsep, order,
        input  opcode, opcode_n, addr, long_order, order_flash_rdy, capture_err
    );

    modport slave (
        input  digit_tick, mc_start, g13, epsep, order,
        output opcode, opcode_n, addr, long_order, order_flash_rdy, capture_err
    );
endinterface

// File: rtl/order_flash_gen.sv
// Order Flashing Unit (main control Stage 2): deserialises the order word by digit position
// and holds opcode / address / length fields for the decoder until epsep.
`timescale 1ns/1ps
module order_flash_gen #(
    parameter int DIGITS     = 36,
    parameter int BASE_DIGIT = 18,
    parameter int ORDER_BITS = 18,
    parameter int LEN_BIT    = 0,
    parameter int ADDR_LSB   = 1,
    parameter int ADDR_W     = 10,
    parameter int OPC_LSB    = 13,
    parameter int OPC_W      = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    order_flash_gen_if.slave  bus
);
    localparam int CNT_W = $clog2(DIGITS);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_READY   = 2'd2;

    localparam logic [63:0] LEN_M  = 64'd1 << LEN_BIT;
    localparam logic [63:0] ADDR_M = ((64'd1 << ADDR_W) - 64'd1) << ADDR_LSB;
    localparam logic [63:0] OPC_M  = ((64'd1 << OPC_W) - 64'd1) << OPC_LSB;
    // Order bits that belong to no field are never stored.
    localparam logic [ORDER_BITS-1:0] KEEP_M = ORDER_BITS'(LEN_M | ADDR_M | OPC_M);

    if (BASE_DIGIT + ORDER_BITS > DIGITS) begin : g_bad_window
        $error("order window runs past the end of the minor cycle");
    end
    if ((LEN_BIT >= ORDER_BITS) || (ADDR_LSB + ADDR_W > ORDER_BITS) || (OPC_LSB + OPC_W > ORDER_BITS)) begin : g_bad_field
        $error("a field extends beyond the captured order bits");
    end
    if (((LEN_M & ADDR_M) != 64'd0) || ((LEN_M & OPC_M) != 64'd0) || ((ADDR_M & OPC_M) != 64'd0)) begin : g_overlap
        $error("order fields overlap");
    end

    logic [1:0]            state_r, state_nxt_s;
    logic [CNT_W-1:0]      cnt_r, cnt_nxt_s, cur_s;
    logic [ORDER_BITS-1:0] word_r, word_nxt_s;
    logic                  rdy_r, rdy_nxt_s;
    logic                  err_r, err_nxt_s;
    logic                  store_s;
    logic                  in_win_s;
    int                    idx_s;

    // Next digit count, capture FSM and field update.
    always_comb begin
        if (bus.mc_start) begin
            cur_s = {CNT_W{1'b0}};
        end else if (cnt_r == CNT_W'(DIGITS - 1)) begin
            cur_s = {CNT_W{1'b0}};
        end else begin
            cur_s = cnt_r + CNT_W'(1);
        end
        idx_s       = int'(cur_s) - BASE_DIGIT;
        in_win_s    = (idx_s >= 0) && (idx_s < ORDER_BITS);
        cnt_nxt_s   = bus.digit_tick ? cur_s : cnt_r;
        state_nxt_s = state_r;
        word_nxt_s  = word_r;
        rdy_nxt_s   = rdy_r;
        err_nxt_s   = 1'b0;
        store_s     = 1'b0;

        // epsep wins over any tick in the same cycle and never raises capture_err.
        if (bus.epsep) begin
            state_nxt_s = ST_IDLE;
            word_nxt_s  = {ORDER_BITS{1'b0}};
            rdy_nxt_s   = 1'b0;
        end else if (bus.digit_tick) begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.g13 && (idx_s == 0)) begin
                        store_s     = 1'b1;
                        state_nxt_s = (ORDER_BITS == 1) ? ST_READY : ST_CAPTURE;
                        rdy_nxt_s   = (ORDER_BITS == 1) ? 1'b1 : 1'b0;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_CAPTURE: begin
                    if (!bus.g13 || !in_win_s) begin
                        state_nxt_s = ST_IDLE;
                        word_nxt_s  = {ORDER_BITS{1'b0}};
                        err_nxt_s   = 1'b1;
                    end else if (idx_s == ORDER_BITS - 1) begin
                        store_s     = 1'b1;
                        state_nxt_s = ST_READY;
                        rdy_nxt_s   = 1'b1;
                    end else begin
                        store_s     = 1'b1;
                    end
                end
                ST_READY: begin
                    state_nxt_s = ST_READY;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    word_nxt_s  = {ORDER_BITS{1'b0}};
                    rdy_nxt_s   = 1'b0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end

        for (int k = 0; k < ORDER_BITS; k++) begin
            word_nxt_s[k] = (store_s && (idx_s == k) && KEEP_M[k]) ? bus.order : word_nxt_s[k];
        end
    end

    // State, digit count and captured order word registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            word_r  <= {ORDER_BITS{1'b0}};
            rdy_r   <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            word_r  <= word_nxt_s;
            rdy_r   <= rdy_nxt_s;
            err_r   <= err_nxt_s;
        end
    end

    assign bus.opcode          = word_r[OPC_LSB +: OPC_W];
    assign bus.opcode_n        = ~word_r[OPC_LSB +: OPC_W];
    assign bus.addr            = word_r[ADDR_LSB +: ADDR_W];
    assign bus.long_order      = word_r[LEN_BIT];
    assign bus.order_flash_rdy = rdy_r;
    assign bus.capture_err     = err_r;
endmodule

// File: tb/tb_order_flash_gen.sv
// Bench for order_flash_gen: randomized order trains, word-level reference model feeding a
// scoreboard queue, and a monitor that checks every rdy rise and capture_err pulse.
`timescale 1ns/1ps
module tb_order_flash_gen;
    localparam int DIGITS = 36;
    localparam int BASE   = 18;
    localparam int NB     = 18;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    order_flash_gen_if #(.OPC_W(5), .ADDR_W(10)) bus ();
    order_flash_gen dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        bit         is_err;
        logic [4:0] opc;
        logic [9:0] addr;
        logic       len;
    } ev_t;

    ev_t  exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   m_digit = 0;
    int   m_mode  = 0;      // 0 waiting, 1 collecting bits, 2 word complete
    bit   m_bits[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: an order is the 18 bits seen on consecutive ticks of digits 18..35 with g13 held.
    function automatic void model_step(input bit tick, input bit ms, input bit g, input bit ep, input bit ord);
        int d;
        ev_t e;
        logic [17:0] w;
        d = m_digit;
        if (tick) begin
            d = ms ? 0 : ((m_digit == DIGITS - 1) ? 0 : m_digit + 1);
            m_digit = d;
        end
        if (ep) begin
            m_mode = 0;
            m_bits.delete();
        end else if (tick) begin
            if (m_mode == 1) begin
                if (!g || (d != BASE + m_bits.size())) begin
                    m_mode = 0;
                    m_bits.delete();
                    e.is_err = 1'b1; e.opc = 5'd0; e.addr = 10'd0; e.len = 1'b0;
                    exp_q.push_back(e);
                end else begin
                    m_bits.push_back(ord);
                    if (m_bits.size() == NB) begin
                        w = 18'd0;
                        for (int k = 0; k < NB; k++) w[k] = m_bits[k];
                        e.is_err = 1'b0; e.opc = w[17:13]; e.addr = w[10:1]; e.len = w[0];
                        exp_q.push_back(e);
                        m_mode = 2;
                    end
                end
            end else if ((m_mode == 0) && g && (d == BASE)) begin
                m_bits.delete();
                m_bits.push_back(ord);
                m_mode = 1;
            end
        end
    endfunction

    task automatic step(input bit tick, input bit ms, input bit g, input bit ep, input bit ord);
        bus.digit_tick = tick;
        bus.mc_start   = ms;
        bus.g13        = g;
        bus.epsep      = ep;
        bus.order      = ord;
        model_step(tick, ms, g, ep, ord);
        @(posedge clk);
        #1;
    endtask

    // One minor cycle of ticks (each followed by an idle clock except the last one).
    task automatic run_minor(input logic [17:0] w, input bit first_ms, input int g_from, input int g_off,
                             input int ep_at, input int ms_at, input int stop_at);
        for (int d = 0; d < stop_at; d++) begin
            bit g;
            bit ord;
            g   = (d >= g_from) && (d < g_off);
            ord = (d >= BASE) ? w[d - BASE] : bit'($urandom_range(1, 0));
            step(1'b1, (d == 0 && first_ms) || (d == ms_at), g, d == ep_at, ord);
            if (d != stop_at - 1) step(1'b0, 1'b0, g, 1'b0, bit'($urandom_range(1, 0)));
        end
    endtask

    // Scoreboard monitor: every rdy rise or capture_err pulse must match the next expected event.
    logic prev_rdy = 1'b0;
    always @(negedge clk) begin
        ev_t e;
        if (rst_n && ((bus.order_flash_rdy && !prev_rdy) || bus.capture_err)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got err=%0b rdy=%0b opc=%h addr=%h, no event expected",
                         bus.capture_err, bus.order_flash_rdy, bus.opcode, bus.addr);
            end else begin
                e = exp_q.pop_front();
                if ((bus.capture_err !== e.is_err) || (bus.order_flash_rdy !== !e.is_err) ||
                    (bus.opcode !== e.opc) || (bus.opcode_n !== ~e.opc) ||
                    (bus.addr !== e.addr) || (bus.long_order !== e.len)) begin
                    errors++;
                    $display("FAIL event: got err=%0b rdy=%0b opc=%h opc_n=%h addr=%h len=%0b expected err=%0b rdy=%0b opc=%h opc_n=%h addr=%h len=%0b",
                             bus.capture_err, bus.order_flash_rdy, bus.opcode, bus.opcode_n, bus.addr, bus.long_order,
                             e.is_err, !e.is_err, e.opc, ~e.opc, e.addr, e.len);
                end
            end
        end
        prev_rdy <= bus.order_flash_rdy;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [17:0] w;
        bus.digit_tick = 1'b0; bus.mc_start = 1'b0; bus.g13 = 1'b0; bus.epsep = 1'b0; bus.order = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_opcode",   32'(bus.opcode), 32'h0);
        chk("reset_opcode_n", 32'(bus.opcode_n), 32'h1F);
        chk("reset_addr",     32'(bus.addr), 32'h0);
        chk("reset_long",     32'(bus.long_order), 32'h0);
        chk("reset_rdy",      32'(bus.order_flash_rdy), 32'h0);
        chk("reset_err",      32'(bus.capture_err), 32'h0);
        rst_n = 1'b1;
        m_digit = 0;

        // Nominal word, checking latency around the digit-35 tick.
        w = 18'h2A0C5;
        run_minor(w, 1'b1, 0, 36, -1, -1, 35);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t2_rdy_before_last", 32'(bus.order_flash_rdy), 32'h0);
        step(1'b1, 1'b0, 1'b1, 1'b0, w[17]);
        chk("t2_rdy",      32'(bus.order_flash_rdy), 32'h1);
        chk("t2_opcode",   32'(bus.opcode), 32'h15);
        chk("t2_opcode_n", 32'(bus.opcode_n), 32'h0A);
        chk("t2_addr",     32'(bus.addr), 32'h062);
        chk("t2_long",     32'(bus.long_order), 32'h1);

        // Hold through two minor cycles of random order, then clear.
        run_minor(18'($urandom), 1'b0, 0, 36, -1, -1, 36);
        run_minor(18'($urandom), 1'b0, 0, 36, -1, -1, 36);
        chk("t3_hold_opcode", 32'(bus.opcode), 32'h15);
        chk("t3_hold_addr",   32'(bus.addr), 32'h062);
        chk("t3_hold_rdy",    32'(bus.order_flash_rdy), 32'h1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t3_clr_opcode",   32'(bus.opcode), 32'h0);
        chk("t3_clr_opcode_n", 32'(bus.opcode_n), 32'h1F);
        chk("t3_clr_addr",     32'(bus.addr), 32'h0);
        chk("t3_clr_long",     32'(bus.long_order), 32'h0);
        chk("t3_clr_rdy",      32'(bus.order_flash_rdy), 32'h0);
        run_minor(18'h3FFFF, 1'b1, 0, 36, -1, -1, 36);
        chk("t3_ones_opcode",   32'(bus.opcode), 32'h1F);
        chk("t3_ones_opcode_n", 32'(bus.opcode_n), 32'h0);
        chk("t3_ones_addr",     32'(bus.addr), 32'h3FF);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        // g13 rising mid-word waits for the next minor cycle.
        run_minor(18'($urandom), 1'b1, 25, 36, -1, -1, 36);
        chk("t4_no_rdy",  32'(bus.order_flash_rdy), 32'h0);
        chk("t4_no_addr", 32'(bus.addr), 32'h0);
        w = 18'($urandom);
        run_minor(w, 1'b0, 0, 36, -1, -1, 36);
        chk("t4_rdy",  32'(bus.order_flash_rdy), 32'h1);
        chk("t4_addr", 32'(bus.addr), 32'(w[10:1]));
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // g13 falls at digit 27.
        run_minor(18'h3FFFF, 1'b1, 0, 27, -1, -1, 36);
        chk("t5_rdy",    32'(bus.order_flash_rdy), 32'h0);
        chk("t5_addr",   32'(bus.addr), 32'h0);
        chk("t5_opcode", 32'(bus.opcode), 32'h0);

        // epsep on the last-bit tick, then mc_start forced mid-capture.
        run_minor(18'h3FFFF, 1'b1, 0, 36, 35, -1, 36);
        chk("t6_ep_rdy",  32'(bus.order_flash_rdy), 32'h0);
        chk("t6_ep_addr", 32'(bus.addr), 32'h0);
        run_minor(18'h3FFFF, 1'b1, 0, 36, -1, 30, 36);
        chk("t6_ms_rdy",  32'(bus.order_flash_rdy), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Random soak: all checking through the scoreboard.
        for (int i = 0; i < 10; i++) begin
            int gf, go, ep;
            gf = ($urandom_range(2, 0) == 0) ? int'($urandom_range(35, 0)) : 0;
            go = ($urandom_range(2, 0) == 0) ? int'($urandom_range(35, 19)) : 36;
            ep = ($urandom_range(3, 0) == 0) ? int'($urandom_range(35, 0)) : -1;
            run_minor(18'($urandom), bit'($urandom_range(1, 0)), gf, go, ep, -1, 36);
            if ($urandom_range(1, 0) == 1) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a capture.
        run_minor(18'h3FFFF, 1'b1, 0, 36, -1, -1, 30);
        chk("t1_pre_addr", 32'(bus.addr), 32'h3FF);
        #2;
        rst_n = 1'b0;
        m_mode = 0;
        m_bits.delete();
        m_digit = 0;
        #1;
        chk("t1_opcode",   32'(bus.opcode), 32'h0);
        chk("t1_opcode_n", 32'(bus.opcode_n), 32'h1F);
        chk("t1_addr",     32'(bus.addr), 32'h0);
        chk("t1_rdy",      32'(bus.order_flash_rdy), 32'h0);
        bus.digit_tick = 1'b0; bus.mc_start = 1'b0; bus.g13 = 1'b0; bus.order = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
